// File: rtl/cache_line_reader_if.sv
// cache_line_reader_if: groups the signals of a cache_line_reader into one bundle.
//   core side   : req_valid/req_ready/req_addr, resp_valid/resp_ready/resp_data/resp_hit, flush
//   line side   : line_valid/line_tag/line_data (read), line_overwrite/line_wr_* (write)
//   memory side : mem_req_valid/mem_req_ready/mem_req_addr, mem_resp_valid/mem_resp_data
// Modports: slave = the reader block itself, master = its environment (core, line, memory).
interface cache_line_reader_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int REG_LEN      = 32,
    parameter int LINE_BYTES   = 16
) ();
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS;
    localparam int LINE_LEN    = LINE_BYTES * 8;

    logic                    req_valid;
    logic                    req_ready;
    logic [ADDRESS_BITS-1:0] req_addr;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [REG_LEN-1:0]      resp_data;
    logic                    resp_hit;
    logic                    flush;
    logic                    line_valid;
    logic [TAG_BITS-1:0]     line_tag;
    logic [LINE_LEN-1:0]     line_data;
    logic                    line_overwrite;
    logic                    line_wr_valid;
    logic [TAG_BITS-1:0]     line_wr_tag;
    logic [LINE_LEN-1:0]     line_wr_data;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDRESS_BITS-1:0] mem_req_addr;
    logic                    mem_resp_valid;
    logic [LINE_LEN-1:0]     mem_resp_data;

    modport slave (
        input  req_valid, req_addr, resp_ready, flush,
        input  line_valid, line_tag, line_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, resp_hit,
        output line_overwrite, line_wr_valid, line_wr_tag, line_wr_data,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, resp_ready, flush,
        output line_valid, line_tag, line_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, resp_hit,
        input  line_overwrite, line_wr_valid, line_wr_tag, line_wr_data,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/cache_line_reader.sv
// cache_line_reader: read-side controller for one external cache line.
// A load is looked up against the stored valid/tag; a hit returns the addressed
// word, a miss fetches the whole line from memory, rewrites the line and then
// returns the word. Flush requests are queued and invalidate the line once idle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : cache_line_reader_if.slave (core, line and memory signals)
//   hit_count, miss_count : lookup statistics, only with CACHE_READER_STATS_EN defined
module cache_line_reader #(
    parameter int ADDRESS_BITS = 32,
    parameter int REG_LEN      = 32,
    parameter int LINE_BYTES   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cache_line_reader_if.slave        bus
`ifdef CACHE_READER_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS;
    localparam int LINE_LEN    = LINE_BYTES * 8;
    localparam int BYTE_BITS   = $clog2(REG_LEN / 8);
    localparam int WORDS       = LINE_LEN / REG_LEN;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t               state_r, next_s;
    logic                 flush_pending_r;
    logic [TAG_BITS-1:0]  tag_r;
    logic [OFFSET_BITS-1:0] off_r;
    logic [REG_LEN-1:0]   resp_data_r;
    logic                 resp_hit_r;

    logic                 req_ready_s, resp_valid_s, mem_req_valid_s;
    logic                 line_ow_s, line_wr_valid_s;
    logic [TAG_BITS-1:0]  line_wr_tag_s;
    logic [LINE_LEN-1:0]  line_wr_data_s;
    logic                 latch_req_s, lookup_hit_s, clear_flush_s;
    logic                 capture_hit_s, capture_refill_s;

    // Word i of a line sits at bits [i*REG_LEN +: REG_LEN]; byte bits below a word are ignored.
    function automatic logic [REG_LEN-1:0] select_word(input logic [LINE_LEN-1:0] line,
                                                       input logic [OFFSET_BITS-1:0] off);
        logic [REG_LEN-1:0] w;
        w = '0;
        for (int i = 0; i < WORDS; i++) begin
            w = ((off >> BYTE_BITS) == OFFSET_BITS'(i)) ? line[i*REG_LEN +: REG_LEN] : w;
        end
        return w;
    endfunction

    // Next-state decode and per-state outputs.
    always_comb begin
        next_s           = state_r;
        req_ready_s      = 1'b0;
        resp_valid_s     = 1'b0;
        mem_req_valid_s  = 1'b0;
        line_ow_s        = 1'b0;
        line_wr_valid_s  = 1'b0;
        line_wr_tag_s    = '0;
        line_wr_data_s   = '0;
        latch_req_s      = 1'b0;
        clear_flush_s    = 1'b0;
        capture_hit_s    = 1'b0;
        capture_refill_s = 1'b0;
        lookup_hit_s     = bus.line_valid && (bus.line_tag == tag_r);
        case (state_r)
            IDLE: begin
                if (flush_pending_r) begin
                    // Invalidate write; a waiting request is held off this cycle.
                    line_ow_s     = 1'b1;
                    clear_flush_s = 1'b1;
                    next_s        = IDLE;
                end else begin
                    req_ready_s = 1'b1;
                    if (bus.req_valid) begin
                        latch_req_s = 1'b1;
                        next_s      = LOOKUP;
                    end else begin
                        next_s = IDLE;
                    end
                end
            end
            LOOKUP: begin
                if (lookup_hit_s) begin
                    capture_hit_s = 1'b1;
                    next_s        = RESP;
                end else begin
                    next_s = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid_s = 1'b1;
                if (bus.mem_req_ready) begin
                    next_s = MEM_WAIT;
                end else begin
                    next_s = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    line_ow_s        = 1'b1;
                    line_wr_valid_s  = 1'b1;
                    line_wr_tag_s    = tag_r;
                    line_wr_data_s   = bus.mem_resp_data;
                    capture_refill_s = 1'b1;
                    next_s           = RESP;
                end else begin
                    next_s = MEM_WAIT;
                end
            end
            RESP: begin
                resp_valid_s = 1'b1;
                if (bus.resp_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = RESP;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State, latched request, pending flush and response word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            flush_pending_r <= 1'b0;
            tag_r           <= '0;
            off_r           <= '0;
            resp_data_r     <= '0;
            resp_hit_r      <= 1'b0;
        end else begin
            state_r <= next_s;
            // A flush landing in the invalidate cycle is already covered by that write,
            // which also keeps line_overwrite from firing on two consecutive cycles.
            if (clear_flush_s) begin
                flush_pending_r <= 1'b0;
            end else begin
                flush_pending_r <= flush_pending_r | bus.flush;
            end
            if (latch_req_s) begin
                tag_r <= bus.req_addr[ADDRESS_BITS-1:OFFSET_BITS];
                off_r <= bus.req_addr[OFFSET_BITS-1:0];
            end else begin
                tag_r <= tag_r;
                off_r <= off_r;
            end
            if (capture_hit_s) begin
                resp_data_r <= select_word(bus.line_data, off_r);
                resp_hit_r  <= 1'b1;
            end else if (capture_refill_s) begin
                resp_data_r <= select_word(bus.mem_resp_data, off_r);
                resp_hit_r  <= 1'b0;
            end else begin
                resp_data_r <= resp_data_r;
                resp_hit_r  <= resp_hit_r;
            end
        end
    end

`ifdef CACHE_READER_STATS_EN
    // Lookup statistics, counted in the LOOKUP cycle, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state_r == LOOKUP) begin
            hit_count  <= hit_count + {31'd0, lookup_hit_s};
            miss_count <= miss_count + {31'd0, !lookup_hit_s};
        end else begin
            hit_count  <= hit_count;
            miss_count <= miss_count;
        end
    end
`endif

    assign bus.req_ready      = req_ready_s;
    assign bus.resp_valid     = resp_valid_s;
    assign bus.resp_data      = resp_data_r;
    assign bus.resp_hit       = resp_hit_r;
    assign bus.line_overwrite = line_ow_s;
    assign bus.line_wr_valid  = line_wr_valid_s;
    assign bus.line_wr_tag    = line_wr_tag_s;
    assign bus.line_wr_data   = line_wr_data_s;
    assign bus.mem_req_valid  = mem_req_valid_s;
    assign bus.mem_req_addr   = mem_req_valid_s ? {tag_r, {OFFSET_BITS{1'b0}}} : '0;

endmodule

// File: tb/tb_cache_line_reader.sv
// tb_cache_line_reader: randomized self-checking bench for cache_line_reader.
// The bench plays core, line storage and memory. Expected results come from a
// transaction-level model: a memory image function and the remembered valid/tag
// of the line.
module tb_cache_line_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_reader_if bus ();
`ifdef CACHE_READER_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_line_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef CACHE_READER_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // line storage element living outside the block
    logic         lv_q = 1'b0;
    logic [27:0]  lt_q = 28'd0;
    logic [127:0] ld_q = 128'd0;
    always @(posedge clk) begin
        if (bus.line_overwrite) begin
            lv_q <= bus.line_wr_valid;
            lt_q <= bus.line_wr_tag;
            ld_q <= bus.line_wr_data;
        end
    end
    assign bus.line_valid = lv_q;
    assign bus.line_tag   = lt_q;
    assign bus.line_data  = ld_q;

    // protocol monitors
    int   memreq_hs = 0;
    int   ow_consec = 0;
    logic ow_prev = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_req_valid && bus.mem_req_ready) memreq_hs <= memreq_hs + 1;
        if (bus.line_overwrite && ow_prev) ow_consec <= ow_consec + 1;
        ow_prev <= bus.line_overwrite;
    end

    int n_checks = 0;
    int n_pass = 0;

    // reference model state
    bit          ref_valid = 1'b0;
    logic [27:0] ref_tag = 28'd0;
    int          exp_memreq = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // memory image: line content as a function of its line-aligned address
    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (la == 32'h0000_1000) return 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        return {la ^ 32'hA5A5_0000, la * 32'd3, ~la, la + 32'h1234_5678};
    endfunction

    task automatic do_load(input logic [31:0] addr, input int stall, input int rq_dly,
                           input int rs_dly, input bit flush_wait);
        logic [27:0]  tag;
        logic [127:0] ln;
        logic [31:0]  word;
        bit           hit;
        int           n;
        tag  = addr[31:4];
        ln   = mem_line({tag, 4'h0});
        word = ln[addr[3:2]*32 +: 32];
        hit  = ref_valid && (ref_tag == tag);
        n = 0;
        settle;
        while (!bus.req_ready && n < 20) begin
            tick;
            n++;
        end
        check_eq("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        settle;
        check_eq("lookup_quiet", {bus.resp_valid, bus.req_ready, bus.mem_req_valid}, 3'b000);
        if (hit) exp_hits++;
        else exp_misses++;
        if (!hit) begin
            tick;
            for (int d = 0; d <= rq_dly; d++) begin
                bus.mem_req_ready = (d == rq_dly);
                settle;
                check_eq("mem_req_valid", bus.mem_req_valid, 1'b1);
                check_eq("mem_req_addr", bus.mem_req_addr, {tag, 4'h0});
                tick;
            end
            bus.mem_req_ready = 1'b0;
            exp_memreq++;
            for (int d = 0; d < rs_dly; d++) begin
                bus.flush = flush_wait && (d == 0);
                settle;
                check_eq("wait_quiet", {bus.line_overwrite, bus.resp_valid, bus.mem_req_valid}, 3'b000);
                tick;
            end
            bus.flush          = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = ln;
            settle;
            check_eq("refill_ow", {bus.line_overwrite, bus.line_wr_valid}, 2'b11);
            check_eq("refill_tag", bus.line_wr_tag, tag);
            check_eq("refill_data", bus.line_wr_data, ln);
            tick;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            ref_valid = 1'b1;
            ref_tag   = tag;
        end else begin
            tick;
        end
        settle;
        check_eq("resp_valid", bus.resp_valid, 1'b1);
        check_eq("resp_data", bus.resp_data, word);
        check_eq("resp_hit", bus.resp_hit, hit);
        for (int s = 0; s < stall; s++) begin
            bus.resp_ready     = 1'b0;
            bus.req_valid      = 1'($urandom % 2);
            bus.mem_resp_valid = 1'($urandom % 2);
            settle;
            check_eq("stall_hold", {bus.resp_valid, bus.resp_hit, bus.resp_data}, {1'b1, hit, word});
            check_eq("stall_busy", {bus.req_ready, bus.line_overwrite}, 2'b00);
            tick;
        end
        bus.req_valid      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.resp_ready     = 1'b1;
        tick;
        bus.resp_ready = 1'b0;
        if (flush_wait && !hit) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = $urandom;
            settle;
            check_eq("flush_ow", {bus.line_overwrite, bus.line_wr_valid, bus.req_ready}, 3'b100);
            tick;
            bus.req_valid = 1'b0;
            ref_valid = 1'b0;
            settle;
            check_eq("ready_after_flush", {bus.req_ready, bus.line_overwrite}, 2'b10);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr = 32'd0;
        bus.resp_ready = 1'b0;
        bus.flush = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = 128'd0;
        tick;
        tick;
        check_eq("rst_ready", bus.req_ready, 1'b1);
        check_eq("rst_quiet", {bus.resp_valid, bus.resp_hit, bus.mem_req_valid, bus.line_overwrite}, 4'b0000);
        check_eq("rst_data", {bus.resp_data, bus.mem_req_addr}, 64'd0);
        rst_n = 1'b1;
        tick;

        // directed cases
        do_load(32'h0000_1004, 0, 0, 1, 1'b0);
        do_load(32'h0000_100C, 5, 0, 0, 1'b0);
        do_load(32'h0000_2008, 0, 3, 2, 1'b0);
        do_load(32'h0000_3004, 1, 1, 2, 1'b1);
        do_load(32'h0000_3004, 0, 0, 0, 1'b0);

        // randomized loads over a few lines so hits and misses both occur
        for (int k = 0; k < 50; k++) begin
            logic [31:0] a;
            int rs;
            bit fw;
            a  = 32'h0000_1000 + (32'($urandom_range(0, 3)) << 4) + 32'($urandom_range(0, 15));
            fw = ($urandom_range(0, 5) == 0);
            rs = $urandom_range(0, 3);
            if (fw && rs == 0) rs = 1;
            do_load(a, $urandom_range(0, 3), $urandom_range(0, 3), rs, fw);
        end

`ifdef CACHE_READER_STATS_EN
        check_eq("hit_count", hit_count, exp_hits);
        check_eq("miss_count", miss_count, exp_misses);
`endif

        // reset while waiting for refill data
        settle;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hBEEF_0008;
        tick;
        bus.req_valid = 1'b0;
        tick;
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        exp_memreq++;
        settle;
        rst_n = 1'b0;
        settle;
        check_eq("mid_rst_quiet", {bus.resp_valid, bus.mem_req_valid, bus.line_overwrite, bus.resp_hit}, 4'b0000);
        check_eq("mid_rst_data", {bus.resp_data, bus.mem_req_addr}, 64'd0);
        check_eq("mid_rst_ready", bus.req_ready, 1'b1);
        exp_hits = 0;
        exp_misses = 0;
        tick;
        rst_n = 1'b1;
        tick;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_line(32'hBEEF_0000);
        settle;
        check_eq("stale_resp_ow", bus.line_overwrite, 1'b0);
        tick;
        bus.mem_resp_valid = 1'b0;
        settle;
        check_eq("stale_resp_valid", {bus.resp_valid, bus.req_ready}, 2'b01);

        // the line is untouched, so the model's view still predicts the next load
        do_load(32'h0000_1008, 0, 0, 1, 1'b0);

        tick;
        check_eq("mem_req_count", memreq_hs, exp_memreq);
        check_eq("ow_consecutive", ow_consec, 0);
`ifdef CACHE_READER_STATS_EN
        check_eq("hit_count_end", hit_count, exp_hits);
        check_eq("miss_count_end", miss_count, exp_misses);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
